system_control_unit: RTL and testbench
======================================

# system_control_unit

Parametrised system-register and exception-control block for the cpu32e2 core, successor to the fixed four-register system block. It holds flags, interrupt enable, exception mask, ISR base address, system-call number and cause. It adds:
- a sticky interrupt-pending register for IRQ_COUNT external lines, with masked lowest-index arbitration;
- a STACK_DEPTH-deep save/restore stack of {flags, interruptEnable} for nested exception entry and return.

## Interface
- IRQ_COUNT, 8, number of external interrupt lines (1..16), mapped to causes 16..16+IRQ_COUNT-1
- STACK_DEPTH, 4, entries in the save/restore stack (2..16)
- ISR_RESET, 32'd4, reset value of isrBaseAddress
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- exceptionPending  in  1  suppresses all register-file writes (writeEn, flagsWriteEn) this cycle
- writeEn  in  1  register-file write strobe
- writeAddr  in  5  destination system register (DRL)
- writeData  in  32  write data (register file B)
- flagsWriteEn  in  1  ALU flags update strobe
- resultFlags  in  4  ALU result flags
- systemCallEn  in  1  capture systemCallNumber (not suppressed by exceptionPending)
- systemCallNumber  in  6  IMM6 of SYSCALL
- readAddr  in  5  source system register (SRB)
- irq  in  IRQ_COUNT  level interrupt lines, already synchronised to clk
- exceptionEnter  in  1  one-cycle pulse: exception/interrupt taken
- exceptionCause  in  5  cause accompanying exceptionEnter
- exceptionReturn  in  1  one-cycle pulse: return from exception
- readData  out  32  combinational read of readAddr
- flags  out  4  current flags
- interruptEnable  out  1  global interrupt enable
- exceptionMask  out  16  exception/interrupt mask
- isrBaseAddress  out  32  ISR table base
- interruptRequest  out  1  an enabled, unmasked IRQ is pending
- interruptCause  out  5  cause of highest-priority pending IRQ (0 when none)
- isrVector  out  32  isrBaseAddress + (exceptionCause << 2)

## Operation
- Reset values: flags 0; interruptEnable 0; exceptionMask 0; isrBaseAddress ISR_RESET; systemCall 0; cause 0; pending 0; stack depth 0; overflow/underflow 0. With these values all derived outputs are 0, except isrVector = ISR_RESET + (exceptionCause<<2).
- Register map, read and write:
  - sys0: {28'b0, flags}
  - sys1: {exceptionMask, interruptEnable, 10'b0, cause}; write loads mask = [31:16] and IE = [15]; cause is read-only
  - sys2: isrBaseAddress
  - sys3: {26'b0, systemCall}, read-only
  - sys4: {(32-IRQ_COUNT)'b0, pending}; write-1-to-clear
  - sys5: {depth[4:0] at [12:8], 6'b0, underflow at [1], overflow at [0]}; write-1-to-clear [1:0]
  - Other addresses read 0; writes to them are ignored.
- Pending register:
  - pending[i] is set in every cycle that irq[i]=1.
  - A same-cycle set beats W1C or acknowledge.
- Arbitration:
  - active = pending & exceptionMask[IRQ_COUNT-1:0]
  - interruptRequest = interruptEnable && |active
  - interruptCause = 16 + lowest set index of active, or 0 when active is 0
- exceptionEnter:
  - Pushes {flags, interruptEnable}, clears interruptEnable, and loads cause = exceptionCause.
  - If exceptionCause >= 16, clears pending[exceptionCause-16], subject to the set-wins rule.
  - Stack full: push discarded, existing entries intact, overflow set; IE still cleared and cause still loaded.
- exceptionReturn: pops and restores flags and interruptEnable. Stack empty: no state change, underflow set.
- Priority per cycle, for flags and IE: exceptionEnter > exceptionReturn > writeEn > flagsWriteEn.
  - exceptionEnter and exceptionReturn together: enter taken, return ignored.
  - Any register write in an enter or return cycle is dropped in full, including W1C.
- Writes are ignored while exceptionPending=1. systemCallEn always captures.

## Timing
- All register effects are visible on outputs one cycle after the strobe edge.
- readData, interruptRequest, interruptCause and isrVector are combinational from registered state (isrVector also from exceptionCause).
- irq rises at cycle N: pending at N+1; interruptRequest at N+1 if IE and mask bit are set.
- Enter at cycle N: IE=0 and depth+1 at N+1. Return at cycle M: restored values at M+1.
- Back-to-back enter pulses each push; STACK_DEPTH+1 consecutive enters leave depth=STACK_DEPTH and overflow=1.
- Reset asserted mid-nesting clears the stack and all sticky bits at the next edge.

## Test plan
- Reset, then read sys0..sys5 -> 0, 0, 4, 0, 0, 0. All outputs at reset values.
- Write sys1 = 0x0003_8000; pulse irq[1] -> next cycle interruptRequest=1, interruptCause=17. Then enter with cause 17 -> pending=0, IE=0, cause=17, depth=1.
- flags=0xA, IE=1; enter (cause 5); write sys0=0x3; return -> flags=0xA, IE=1, depth=0.
- Five enters with STACK_DEPTH=4 -> depth=4, sys5[0]=1. Five returns -> depth=0, sys5[1]=1. Write sys5=0x3 -> 0.
- irq[2] held high while writing sys4=0x4 -> pending[2] stays 1. writeEn + exceptionPending -> target register unchanged.
- Enter and return in the same cycle, with writeEn to sys2 -> push happens, isrBaseAddress unchanged, depth+1.

Source files
------------

// File: rtl/system_control_unit.sv
// System-register and exception-control block for the cpu32e2 core.
// Holds flags, interrupt enable, exception mask, ISR base, syscall number and
// cause. Also holds a sticky IRQ pending register with masked lowest-index
// arbitration, and a save/restore stack of {flags, IE} for nested exceptions.
module system_control_unit #(
    parameter int unsigned IRQ_COUNT   = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [31:0] ISR_RESET   = 32'd4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exceptionPending,
    input  logic                 writeEn,
    input  logic [4:0]           writeAddr,
    input  logic [31:0]          writeData,
    input  logic                 flagsWriteEn,
    input  logic [3:0]           resultFlags,
    input  logic                 systemCallEn,
    input  logic [5:0]           systemCallNumber,
    input  logic [4:0]           readAddr,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic                 exceptionEnter,
    input  logic [4:0]           exceptionCause,
    input  logic                 exceptionReturn,
    output logic [31:0]          readData,
    output logic [3:0]           flags,
    output logic                 interruptEnable,
    output logic [15:0]          exceptionMask,
    output logic [31:0]          isrBaseAddress,
    output logic                 interruptRequest,
    output logic [4:0]           interruptCause,
    output logic [31:0]          isrVector
);

    localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]           flags_q, flags_d;
    logic                 ie_q, ie_d;
    logic [15:0]          mask_q, mask_d;
    logic [31:0]          isr_q, isr_d;
    logic [5:0]           syscall_q, syscall_d;
    logic [4:0]           cause_q, cause_d;
    logic [IRQ_COUNT-1:0] pending_q, pending_d;
    logic [4:0]           depth_q, depth_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    // Each entry is {flags[3:0], ie}
    logic [4:0]           stack_q [STACK_DEPTH];
    logic [4:0]           stack_d [STACK_DEPTH];

    logic                 wr_ok;
    logic                 flags_wr_ok;
    logic                 stack_full;
    logic                 stack_empty;
    logic [SW-1:0]        push_idx;
    logic [SW-1:0]        pop_idx;
    logic [4:0]           pop_entry;
    logic [IRQ_COUNT-1:0] ack_clr;
    logic [IRQ_COUNT-1:0] w1c_clr;
    logic [IRQ_COUNT-1:0] active;

    // Register writes are dropped entirely in enter/return cycles.
    assign wr_ok       = writeEn && !exceptionPending && !exceptionEnter && !exceptionReturn;
    assign flags_wr_ok = flagsWriteEn && !exceptionPending;
    assign stack_full  = (depth_q == 5'(STACK_DEPTH));
    assign stack_empty = (depth_q == 5'd0);
    assign push_idx    = depth_q[SW-1:0];
    assign pop_idx     = SW'(depth_q - 5'd1);
    assign pop_entry   = stack_q[pop_idx];

    // Pending clear sources: acknowledge on enter and write-1-to-clear.
    always_comb begin
        ack_clr = '0;
        w1c_clr = '0;
        for (int i = 0; i < int'(IRQ_COUNT); i++) begin
            ack_clr[i] = exceptionEnter && exceptionCause[4] && (exceptionCause[3:0] == 4'(i));
        end
        if (wr_ok && writeAddr == 5'd4) begin
            w1c_clr = writeData[IRQ_COUNT-1:0];
        end
    end

    // Next-state for flags, IE and the save/restore stack.
    always_comb begin
        flags_d = flags_q;
        ie_d    = ie_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (exceptionEnter) begin
            ie_d = 1'b0;
            if (stack_full) begin
                ovf_d = 1'b1;
            end else begin
                stack_d[push_idx] = {flags_q, ie_q};
                depth_d           = depth_q + 5'd1;
            end
        end else if (exceptionReturn) begin
            if (stack_empty) begin
                unf_d = 1'b1;
            end else begin
                flags_d = pop_entry[4:1];
                ie_d    = pop_entry[0];
                depth_d = depth_q - 5'd1;
            end
        end else begin
            if (wr_ok && writeAddr == 5'd0) begin
                flags_d = writeData[3:0];
            end else if (flags_wr_ok) begin
                flags_d = resultFlags;
            end
            if (wr_ok && writeAddr == 5'd1) begin
                ie_d = writeData[15];
            end
            if (wr_ok && writeAddr == 5'd5) begin
                ovf_d = ovf_q & ~writeData[0];
                unf_d = unf_q & ~writeData[1];
            end
        end
    end

    // Next-state for the remaining registers; a new irq level beats any clear.
    always_comb begin
        mask_d    = mask_q;
        isr_d     = isr_q;
        syscall_d = syscall_q;
        cause_d   = cause_q;
        pending_d = (pending_q & ~(ack_clr | w1c_clr)) | irq;
        if (wr_ok && writeAddr == 5'd1) begin
            mask_d = writeData[31:16];
        end
        if (wr_ok && writeAddr == 5'd2) begin
            isr_d = writeData;
        end
        if (systemCallEn) begin
            syscall_d = systemCallNumber;
        end
        if (exceptionEnter) begin
            cause_d = exceptionCause;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            ie_q      <= 1'b0;
            mask_q    <= '0;
            isr_q     <= ISR_RESET;
            syscall_q <= '0;
            cause_q   <= '0;
            pending_q <= '0;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q   <= flags_d;
            ie_q      <= ie_d;
            mask_q    <= mask_d;
            isr_q     <= isr_d;
            syscall_q <= syscall_d;
            cause_q   <= cause_d;
            pending_q <= pending_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            stack_q   <= stack_d;
        end
    end

    // Lowest-index masked pending IRQ wins.
    always_comb begin
        logic found;
        active         = pending_q & mask_q[IRQ_COUNT-1:0];
        interruptCause = 5'd0;
        found          = 1'b0;
        for (int i = 0; i < int'(IRQ_COUNT); i++) begin
            if (active[i] && !found) begin
                interruptCause = 5'(16 + i);
                found          = 1'b1;
            end
        end
        interruptRequest = ie_q && (|active);
    end

    // Combinational register read port.
    always_comb begin
        unique case (readAddr)
            5'd0:    readData = {28'b0, flags_q};
            5'd1:    readData = {mask_q, ie_q, 10'b0, cause_q};
            5'd2:    readData = isr_q;
            5'd3:    readData = {26'b0, syscall_q};
            5'd4:    readData = 32'(pending_q);
            5'd5:    readData = {19'b0, depth_q, 6'b0, unf_q, ovf_q};
            default: readData = 32'd0;
        endcase
    end

    assign flags           = flags_q;
    assign interruptEnable = ie_q;
    assign exceptionMask   = mask_q;
    assign isrBaseAddress  = isr_q;
    assign isrVector       = isr_q + {25'b0, exceptionCause, 2'b0};

endmodule

// File: tb/tb_system_control_unit.sv
// Directed bench for system_control_unit with hand-computed expectations.
module tb_system_control_unit;

    logic        clk;
    logic        reset;
    logic        exceptionPending;
    logic        writeEn;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        flagsWriteEn;
    logic [3:0]  resultFlags;
    logic        systemCallEn;
    logic [5:0]  systemCallNumber;
    logic [4:0]  readAddr;
    logic [7:0]  irq;
    logic        exceptionEnter;
    logic [4:0]  exceptionCause;
    logic        exceptionReturn;
    logic [31:0] readData;
    logic [3:0]  flags;
    logic        interruptEnable;
    logic [15:0] exceptionMask;
    logic [31:0] isrBaseAddress;
    logic        interruptRequest;
    logic [4:0]  interruptCause;
    logic [31:0] isrVector;

    int n_checks;
    int n_fail;

    system_control_unit #(
        .IRQ_COUNT   (8),
        .STACK_DEPTH (4),
        .ISR_RESET   (32'd4)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .exceptionPending (exceptionPending),
        .writeEn          (writeEn),
        .writeAddr        (writeAddr),
        .writeData        (writeData),
        .flagsWriteEn     (flagsWriteEn),
        .resultFlags      (resultFlags),
        .systemCallEn     (systemCallEn),
        .systemCallNumber (systemCallNumber),
        .readAddr         (readAddr),
        .irq              (irq),
        .exceptionEnter   (exceptionEnter),
        .exceptionCause   (exceptionCause),
        .exceptionReturn  (exceptionReturn),
        .readData         (readData),
        .flags            (flags),
        .interruptEnable  (interruptEnable),
        .exceptionMask    (exceptionMask),
        .isrBaseAddress   (isrBaseAddress),
        .interruptRequest (interruptRequest),
        .interruptCause   (interruptCause),
        .isrVector        (isrVector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        readAddr = addr;
        #1;
        check_eq(tag, readData, exp);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        writeEn   = 1'b1;
        writeAddr = addr;
        writeData = data;
        step();
        writeEn   = 1'b0;
    endtask

    task automatic do_enter(input logic [4:0] cause);
        exceptionEnter = 1'b1;
        exceptionCause = cause;
        step();
        exceptionEnter = 1'b0;
        exceptionCause = 5'd0;
    endtask

    task automatic do_return();
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        exceptionPending = 1'b0;
        writeEn          = 1'b0;
        writeAddr        = 5'd0;
        writeData        = 32'd0;
        flagsWriteEn     = 1'b0;
        resultFlags      = 4'd0;
        systemCallEn     = 1'b0;
        systemCallNumber = 6'd0;
        readAddr         = 5'd0;
        irq              = 8'd0;
        exceptionEnter   = 1'b0;
        exceptionCause   = 5'd0;
        exceptionReturn  = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        read_chk(5'd0, 32'd0, "rst_sys0");
        read_chk(5'd1, 32'd0, "rst_sys1");
        read_chk(5'd2, 32'd4, "rst_sys2");
        read_chk(5'd3, 32'd0, "rst_sys3");
        read_chk(5'd4, 32'd0, "rst_sys4");
        read_chk(5'd5, 32'd0, "rst_sys5");
        read_chk(5'd9, 32'd0, "rst_unmapped");
        check_eq("rst_irq_req", 32'(interruptRequest), 32'd0);
        check_eq("rst_irq_cause", 32'(interruptCause), 32'd0);
        check_eq("rst_isr_vec", isrVector, 32'd4);
        exceptionCause = 5'd3;
        #1;
        check_eq("isr_vec_cause3", isrVector, 32'd16);
        exceptionCause = 5'd0;

        // Mask/IE, IRQ pending and acknowledge on enter
        do_write(5'd1, 32'h0003_8000);
        check_eq("mask", 32'(exceptionMask), 32'h0003);
        check_eq("ie_set", 32'(interruptEnable), 32'd1);
        irq = 8'h02;
        step();
        irq = 8'h00;
        check_eq("irq1_req", 32'(interruptRequest), 32'd1);
        check_eq("irq1_cause", 32'(interruptCause), 32'd17);
        read_chk(5'd4, 32'h02, "irq1_pending");
        do_enter(5'd17);
        read_chk(5'd4, 32'h00, "ack_pending");
        check_eq("ack_ie", 32'(interruptEnable), 32'd0);
        read_chk(5'd1, 32'h0003_0011, "ack_sys1");
        read_chk(5'd5, 32'h0000_0100, "ack_depth");
        check_eq("ack_req", 32'(interruptRequest), 32'd0);
        do_return();
        check_eq("ret_ie", 32'(interruptEnable), 32'd1);

        // Save/restore of flags and IE across a nested write
        do_write(5'd0, 32'hA);
        do_enter(5'd5);
        check_eq("enter5_ie", 32'(interruptEnable), 32'd0);
        do_write(5'd0, 32'h3);
        check_eq("inner_flags", 32'(flags), 32'h3);
        do_return();
        check_eq("restore_flags", 32'(flags), 32'hA);
        check_eq("restore_ie", 32'(interruptEnable), 32'd1);
        read_chk(5'd5, 32'd0, "restore_depth");

        // Overflow and underflow
        for (int i = 0; i < 5; i++) do_enter(5'd5);
        read_chk(5'd5, 32'h0000_0401, "ovf_sys5");
        for (int i = 0; i < 5; i++) do_return();
        read_chk(5'd5, 32'h0000_0003, "unf_sys5");
        check_eq("unf_flags", 32'(flags), 32'hA);
        check_eq("unf_ie", 32'(interruptEnable), 32'd1);
        do_write(5'd5, 32'h3);
        read_chk(5'd5, 32'd0, "w1c_sys5");

        // Set beats W1C
        irq = 8'h04;
        step();
        do_write(5'd4, 32'h4);
        read_chk(5'd4, 32'h04, "set_wins_w1c");
        check_eq("unmasked_no_req", 32'(interruptRequest), 32'd0);
        irq = 8'h00;
        do_write(5'd4, 32'hFF);
        read_chk(5'd4, 32'h00, "w1c_pending");

        // Lowest-index arbitration
        do_write(5'd1, 32'h00FF_8000);
        irq = 8'hA0;
        step();
        irq = 8'h00;
        check_eq("arb_a0_cause", 32'(interruptCause), 32'd21);
        check_eq("arb_a0_req", 32'(interruptRequest), 32'd1);
        irq = 8'h08;
        step();
        irq = 8'h00;
        check_eq("arb_a8_cause", 32'(interruptCause), 32'd19);
        do_write(5'd4, 32'hFF);
        check_eq("arb_clr_cause", 32'(interruptCause), 32'd0);

        // Writes suppressed by exceptionPending; syscall still captured
        exceptionPending = 1'b1;
        flagsWriteEn     = 1'b1;
        resultFlags      = 4'h5;
        systemCallEn     = 1'b1;
        systemCallNumber = 6'h2A;
        do_write(5'd2, 32'h0000_1234);
        exceptionPending = 1'b0;
        flagsWriteEn     = 1'b0;
        systemCallEn     = 1'b0;
        check_eq("pend_isr", isrBaseAddress, 32'd4);
        check_eq("pend_flags", 32'(flags), 32'hA);
        read_chk(5'd3, 32'h2A, "syscall_capture");
        flagsWriteEn = 1'b1;
        step();
        flagsWriteEn = 1'b0;
        check_eq("alu_flags", 32'(flags), 32'h5);

        // Enter + return + write in one cycle: only the enter takes effect
        exceptionReturn = 1'b1;
        writeEn         = 1'b1;
        writeAddr       = 5'd2;
        writeData       = 32'h0000_DEAD;
        do_enter(5'd3);
        exceptionReturn = 1'b0;
        writeEn         = 1'b0;
        check_eq("combo_isr", isrBaseAddress, 32'd4);
        check_eq("combo_ie", 32'(interruptEnable), 32'd0);
        read_chk(5'd5, 32'h0000_0100, "combo_depth");
        read_chk(5'd1, 32'h00FF_0003, "combo_sys1");

        // Reset mid-nesting
        do_enter(5'd6);
        read_chk(5'd5, 32'h0000_0200, "nest_depth2");
        reset = 1'b1;
        step();
        reset = 1'b0;
        read_chk(5'd5, 32'd0, "midrst_sys5");
        read_chk(5'd3, 32'd0, "midrst_sys3");
        read_chk(5'd1, 32'd0, "midrst_sys1");
        check_eq("midrst_flags", 32'(flags), 32'd0);
        check_eq("midrst_isr", isrBaseAddress, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
